// File: rtl/asm2ir_stream_if.sv
// Character-in / instruction-out stream bundle for asm2ir_stream.
// master = text source and instruction consumer; slave = the assembler.
interface asm2ir_stream_if;
   logic [7:0]  Char_in;
   logic        Char_valid;
   logic        Char_ready;
   logic [31:0] IR;
   logic        IR_valid;
   logic        IR_ready;
   logic        Asm_err;

   modport master (
      output Char_in, Char_valid, IR_ready,
      input  Char_ready, IR, IR_valid, Asm_err
   );

   modport slave (
      input  Char_in, Char_valid, IR_ready,
      output Char_ready, IR, IR_valid, Asm_err
   );
endinterface

// File: rtl/asm2ir_stream.sv
// Streaming one-line RV32I assembler (R-type ALU ops and I-type ALU immediates).
// Define ASM_IMM_HEX_EN to also accept 0x-prefixed hex immediates.
module asm2ir_stream #(
   parameter logic [31:0] ERR_IR = 32'h00000013
) (
   input  logic            Clk_pin,
   input  logic            Reset_pin,
   asm2ir_stream_if.slave  bus,
   output logic [2:0]      fsm_state
);
   // Handshakes: a character moves when Char_valid && Char_ready; an instruction
   // moves when IR_valid && IR_ready. IR/Asm_err hold while IR_valid && !IR_ready.
   typedef enum logic [2:0] {IDLE, MNEM, SEP, REG, IMM, SKIP, OUT} state_t;

   localparam logic [7:0] CH_NL = 8'h0A, CH_CR = 8'h0D, CH_SP = 8'h20,
                          CH_CM = 8'h2C, CH_MI = 8'h2D, CH_X  = 8'h78;

   state_t      state, state_n;
   logic [31:0] mnem, mnem_n;
   logic [2:0]  mlen, mlen_n;
   logic [16:0] acc, acc_n;
   logic [2:0]  ndig, ndig_n;
   logic        neg, neg_n, hexm, hex_n;
   logic [1:0]  op, op_n;
   logic [4:0]  rd, rd_n, rs1, rs1_n, rs2, rs2_n;
   logic [11:0] imm, imm_n;
   logic        m_i, m_i_n, m_shift, m_shift_n, m_alt, m_alt_n;
   logic [2:0]  m_f3, m_f3_n;
   logic [31:0] ir, ir_n;
   logic        err, err_n;

   logic [7:0]  c;
   logic        is_sep, is_nl, is_cr, is_digit, is_lower;
   logic        dec_ok, dec_i, dec_shift, dec_alt;
   logic [2:0]  dec_f3;
   logic        reg_ok, imm_ok, fail, finish;
   logic [11:0] imm_val;
   logic [31:0] enc;
`ifdef ASM_IMM_HEX_EN
   logic        is_af;
   logic [3:0]  hval;
`endif

   assign c        = bus.Char_in;
   assign is_sep   = (c == CH_SP) || (c == CH_CM);
   assign is_nl    = (c == CH_NL);
   assign is_cr    = (c == CH_CR);
   assign is_digit = (c >= 8'h30) && (c <= 8'h39);
   assign is_lower = (c >= 8'h61) && (c <= 8'h7A);
`ifdef ASM_IMM_HEX_EN
   assign is_af    = (c >= 8'h61) && (c <= 8'h66);
   assign hval     = is_digit ? c[3:0] : c[3:0] + 4'd9;
`endif

   assign reg_ok  = (ndig != 3'd0) && (acc <= 17'd31);
   assign imm_ok  = (ndig != 3'd0) &&
                    (hexm    ? (!m_shift || acc <= 17'd31) :
                     m_shift ? (!neg && acc <= 17'd31) :
                     neg     ? (acc <= 17'd2048) : (acc <= 17'd2047));
   assign imm_val = neg ? 12'd0 - acc[11:0] : acc[11:0];

   always_comb begin
      dec_ok = 1'b1; dec_i = 1'b0; dec_shift = 1'b0; dec_alt = 1'b0; dec_f3 = 3'd0;
      case (mnem)
         {8'h00, "add"}: dec_f3 = 3'd0;
         {8'h00, "sub"}: begin dec_f3 = 3'd0; dec_alt = 1'b1; end
         {8'h00, "sll"}: dec_f3 = 3'd1;
         {8'h00, "xor"}: dec_f3 = 3'd4;
         {16'h0, "or"}:  dec_f3 = 3'd6;
         {8'h00, "and"}: dec_f3 = 3'd7;
         {8'h00, "srl"}: dec_f3 = 3'd5;
         {8'h00, "sra"}: begin dec_f3 = 3'd5; dec_alt = 1'b1; end
         "addi":         begin dec_i = 1'b1; dec_f3 = 3'd0; end
         "xori":         begin dec_i = 1'b1; dec_f3 = 3'd4; end
         "ori":          begin dec_i = 1'b1; dec_f3 = 3'd6; end
         "andi":         begin dec_i = 1'b1; dec_f3 = 3'd7; end
         "slli":         begin dec_i = 1'b1; dec_shift = 1'b1; dec_f3 = 3'd1; end
         "srli":         begin dec_i = 1'b1; dec_shift = 1'b1; dec_f3 = 3'd5; end
         "srai":         begin dec_i = 1'b1; dec_shift = 1'b1; dec_f3 = 3'd5; dec_alt = 1'b1; end
         default:        dec_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_n = state; mnem_n = mnem; mlen_n = mlen; acc_n = acc; ndig_n = ndig;
      neg_n = neg; hex_n = hexm; op_n = op; rd_n = rd; rs1_n = rs1; rs2_n = rs2;
      imm_n = imm; m_i_n = m_i; m_shift_n = m_shift; m_alt_n = m_alt; m_f3_n = m_f3;
      ir_n = ir; err_n = err; fail = 1'b0; finish = 1'b0; enc = 32'h0;
      if (state == OUT) begin
         if (bus.IR_ready) state_n = IDLE;
      end else if (bus.Char_valid && !is_cr) begin
         case (state)
            IDLE: begin
               if (is_lower) begin
                  state_n = MNEM; mnem_n = {24'h0, c}; mlen_n = 3'd1;
               end else if (!(is_sep || is_nl)) fail = 1'b1;
            end
            MNEM: begin
               if (is_lower && mlen != 3'd4) begin
                  mnem_n = {mnem[23:0], c}; mlen_n = mlen + 3'd1;
               end else if (is_sep && dec_ok) begin
                  state_n = SEP; op_n = 2'd0; m_i_n = dec_i; m_shift_n = dec_shift;
                  m_alt_n = dec_alt; m_f3_n = dec_f3;
               end else fail = 1'b1;
            end
            SEP: begin
               if (is_sep) begin
               end else if (is_nl) begin
                  if (op == 2'd3) finish = 1'b1; else fail = 1'b1;
               end else if (c == CH_X && op != 2'd3 && !(m_i && op == 2'd2)) begin
                  state_n = REG; acc_n = 17'd0; ndig_n = 3'd0;
               end else if ((is_digit || c == CH_MI) && m_i && op == 2'd2) begin
                  state_n = IMM; hex_n = 1'b0; neg_n = !is_digit;
                  acc_n = is_digit ? {13'd0, c[3:0]} : 17'd0;
                  ndig_n = is_digit ? 3'd1 : 3'd0;
               end else fail = 1'b1;
            end
            REG: begin
               if (is_digit && ndig != 3'd2) begin
                  acc_n = acc * 17'd10 + {13'd0, c[3:0]}; ndig_n = ndig + 3'd1;
               end else if ((is_sep || is_nl) && reg_ok) begin
                  case (op)
                     2'd0:    rd_n  = acc[4:0];
                     2'd1:    rs1_n = acc[4:0];
                     default: rs2_n = acc[4:0];
                  endcase
                  op_n = op + 2'd1;
                  if (is_sep) state_n = SEP;
                  else if (op == 2'd2) finish = 1'b1;
                  else fail = 1'b1;
               end else fail = 1'b1;
            end
            IMM: begin
               if (is_digit && !hexm) begin
                  if (ndig == 3'd5) fail = 1'b1;
                  else begin acc_n = acc * 17'd10 + {13'd0, c[3:0]}; ndig_n = ndig + 3'd1; end
`ifdef ASM_IMM_HEX_EN
               end else if (hexm && (is_digit || is_af)) begin
                  if (ndig == 3'd3) fail = 1'b1;
                  else begin acc_n = {acc[12:0], hval}; ndig_n = ndig + 3'd1; end
               end else if (c == CH_X && !hexm && !neg && ndig == 3'd1 && acc == 17'd0) begin
                  hex_n = 1'b1; ndig_n = 3'd0;
`endif
               end else if ((is_sep || is_nl) && imm_ok) begin
                  imm_n = imm_val; op_n = 2'd3;
                  if (is_nl) finish = 1'b1; else state_n = SEP;
               end else fail = 1'b1;
            end
            SKIP: begin
               if (is_nl) begin state_n = OUT; ir_n = ERR_IR; err_n = 1'b1; end
            end
            default: state_n = IDLE;
         endcase
         // The newline itself can be the offending character; then skip nothing.
         if (fail) begin
            if (is_nl) begin state_n = OUT; ir_n = ERR_IR; err_n = 1'b1; end
            else state_n = SKIP;
         end
         if (finish) begin
            if (!m_i)
               enc = {1'b0, m_alt, 5'b0, rs2_n, rs1_n, m_f3, rd_n, 7'b0110011};
            else if (m_shift)
               enc = {1'b0, m_alt, 5'b0, imm_n[4:0], rs1_n, m_f3, rd_n, 7'b0010011};
            else
               enc = {imm_n, rs1_n, m_f3, rd_n, 7'b0010011};
            state_n = OUT; ir_n = enc; err_n = 1'b0;
         end
      end
   end

   always_ff @(posedge Clk_pin) begin
      if (Reset_pin) begin
         state <= IDLE; mnem <= 32'h0; mlen <= 3'd0; acc <= 17'd0; ndig <= 3'd0;
         neg <= 1'b0; hexm <= 1'b0; op <= 2'd0; rd <= 5'd0; rs1 <= 5'd0; rs2 <= 5'd0;
         imm <= 12'd0; m_i <= 1'b0; m_shift <= 1'b0; m_alt <= 1'b0; m_f3 <= 3'd0;
         ir <= 32'h0; err <= 1'b0;
      end else begin
         state <= state_n; mnem <= mnem_n; mlen <= mlen_n; acc <= acc_n; ndig <= ndig_n;
         neg <= neg_n; hexm <= hex_n; op <= op_n; rd <= rd_n; rs1 <= rs1_n; rs2 <= rs2_n;
         imm <= imm_n; m_i <= m_i_n; m_shift <= m_shift_n; m_alt <= m_alt_n; m_f3 <= m_f3_n;
         ir <= ir_n; err <= err_n;
      end
   end

   assign bus.IR         = ir;
   assign bus.Asm_err    = err;
   assign bus.IR_valid   = (state == OUT);
   assign bus.Char_ready = (state != OUT);
   assign fsm_state      = state;
endmodule

// File: tb/tb_asm2ir_stream.sv
// Directed bench for asm2ir_stream: text lines in, instruction words checked.
module tb_asm2ir_stream;
   localparam logic [31:0] ERR_IR = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  fsm_state;
   int          errors = 0;
   int          checks = 0;
   logic [32:0] exp_q[$];

   asm2ir_stream_if bus ();

   asm2ir_stream #(.ERR_IR(ERR_IR)) dut (
      .Clk_pin   (clk),
      .Reset_pin (rst),
      .bus       (bus),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_char(input logic [7:0] ch);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.Char_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.Char_ready) begin
         checks++; errors++;
         $error("FAIL char_ready_timeout observed=0 expected=1");
      end
      bus.Char_in = ch;
      bus.Char_valid = 1'b1;
      @(posedge clk);
      #1 bus.Char_valid = 1'b0;
   endtask

   task automatic send_line(input string s, input bit gaps);
      for (int i = 0; i < s.len(); i++) begin
         send_char(s[i]);
         if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
      end
   endtask

   // Called #1 after the newline edge: output must already be presented.
   task automatic expect_out(input string tag);
      logic [32:0] e;
      e = exp_q.pop_front();
      check({tag, "_valid"}, {31'd0, bus.IR_valid}, 32'd1);
      check({tag, "_ir"}, bus.IR, e[31:0]);
      check({tag, "_err"}, {31'd0, bus.Asm_err}, {31'd0, e[32]});
      @(negedge clk);
      bus.IR_ready = 1'b1;
      @(posedge clk);
      #1 bus.IR_ready = 1'b0;
      check({tag, "_drop"}, {31'd0, bus.IR_valid}, 32'd0);
   endtask

   task automatic line_ok(input string tag, input string s, input logic [31:0] exp_ir, input bit gaps);
      exp_q.push_back({1'b0, exp_ir});
      send_line(s, gaps);
      expect_out(tag);
   endtask

   task automatic line_err(input string tag, input string s);
      exp_q.push_back({1'b1, ERR_IR});
      send_line(s, 1'b0);
      expect_out(tag);
   endtask

   task automatic line_none(input string tag, input string s);
      send_line(s, 1'b0);
      repeat (3) begin
         @(negedge clk);
         check(tag, {31'd0, bus.IR_valid}, 32'd0);
      end
   endtask

   initial begin
      bus.Char_in = 8'h00;
      bus.Char_valid = 1'b0;
      bus.IR_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ir", bus.IR, 32'h0);
      check("rst_valid", {31'd0, bus.IR_valid}, 32'd0);
      check("rst_err", {31'd0, bus.Asm_err}, 32'd0);
      check("rst_ready", {31'd0, bus.Char_ready}, 32'd1);

      line_ok("add", "add x3 x1 x2\n", 32'h002081B3, 1'b0);
      line_ok("sub", "sub x5,x6,x7\n", 32'h407302B3, 1'b1);
      line_ok("srai", "srai x1 x2 3\n", 32'h40315093, 1'b0);
      line_ok("addi_m1", "addi x1 x0 -1\n", 32'hFFF00093, 1'b1);
      line_err("addi_2048", "addi x1 x0 2048\n");
      line_ok("xori_max", "  xori x2, x3, 2047 ,\n", 32'h7FF1C113, 1'b0);
      line_ok("addi_min", "addi x1 x0 -2048\n", 32'h80000093, 1'b0);
      line_ok("srli_cr", "srli x7 x8 31\r\n", 32'h01F45393, 1'b1);
      line_err("slli_32", "slli x1 x1 32\n");
      line_err("reg_32", "add x32 x1 x2\n");
      line_err("too_few", "add x1 x2\n");
      line_err("upper", "Add x1 x2 x3\n");
      line_err("six_dig", "addi x1 x0 123456\n");
      line_none("empty", "\n");
      line_none("sep_only", " , \n");

      // Error output held under back-pressure while a character waits.
      exp_q.push_back({1'b1, ERR_IR});
      send_line("mul x1 x2 x3\n", 1'b0);
      begin
         logic [32:0] e;
         e = exp_q.pop_front();
         @(negedge clk);
         bus.Char_in = "o";
         bus.Char_valid = 1'b1;
         for (int k = 0; k < 4; k++) begin
            check("hold_ir", bus.IR, e[31:0]);
            check("hold_err", {31'd0, bus.Asm_err}, {31'd0, e[32]});
            check("hold_ready", {31'd0, bus.Char_ready}, 32'd0);
            @(negedge clk);
         end
         bus.IR_ready = 1'b1;
         @(posedge clk);
         #1 bus.IR_ready = 1'b0;
         check("hold_drop", {31'd0, bus.IR_valid}, 32'd0);
         @(posedge clk);
         #1 bus.Char_valid = 1'b0;
      end
      line_ok("or_after", "r x1 x2 x3\n", 32'h003160B3, 1'b0);

      // Reset discards a partial line.
      send_line("add x3 x", 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", {31'd0, bus.IR_valid}, 32'd0);
      check("mid_rst_ir", bus.IR, 32'h0);
      check("mid_rst_ready", {31'd0, bus.Char_ready}, 32'd1);
      line_ok("and_after_rst", "and x2 x2 x2\n", 32'h00217133, 1'b0);

`ifdef ASM_IMM_HEX_EN
      line_ok("andi_hex", "andi x4 x4 0xff\n", 32'h0FF27213, 1'b0);
`else
      line_err("andi_hex", "andi x4 x4 0xff\n");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
